// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
//
// Purpose: entry layout, bus typedefs and pop-count encodings used by
// inst_fetch_queue and anything that drives its pop_cnt_i port.
// Ports: none (package).
package inst_fetch_queue_pkg;

  localparam int ENTRY_W = 64;

  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  typedef struct packed {
    InstAddrBus pc;
    InstBus     inst;
  } fetch_entry_t;

  // Fetch bundles are two sequential 32-bit instructions.
  function automatic InstAddrBus next_pc(input InstAddrBus pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - dual-push / dual-pop instruction queue between ICache and decode
//
// Purpose: buffers {pc, inst} pairs from the ICache so miss stalls do not
// starve decode. Accepts 1 or 2 instructions per cycle, delivers up to 2 per
// cycle in program order.
// Ports:
//   clk, rst (async, active-low), flush (sync clear, highest priority)
//   push_valid_i, push_single_i, push_pc_i, push_inst1_i, push_inst2_i : fetch side
//   full_o        : fewer than 2 free entries, fetch must hold
//   pop_cnt_i     : entries consumed by decode (3 treated as 2)
//   inst1_o/pc1_o/inst1_valid_o : head entry
//   inst2_o/pc2_o/inst2_valid_o : head+1 entry
//   count_o       : current occupancy
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid_i,
  input  logic             push_single_i,
  input  logic [31:0]      push_pc_i,
  input  logic [31:0]      push_inst1_i,
  input  logic [31:0]      push_inst2_i,
  output logic             full_o,
  input  logic [1:0]       pop_cnt_i,
  output logic [31:0]      inst1_o,
  output logic [31:0]      pc1_o,
  output logic             inst1_valid_o,
  output logic [31:0]      inst2_o,
  output logic [31:0]      pc2_o,
  output logic             inst2_valid_o,
  output logic [PTR_W:0]   count_o
);

  fetch_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W:0]   free_cnt;
  logic             push_acc;
  logic [1:0]       push_n;
  logic [1:0]       pop_req;
  logic [1:0]       pop_n;

  logic             wr0_en, wr1_en;
  fetch_entry_t     wr0_data, wr1_data;

  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);
  assign free_cnt = (PTR_W+1)'(DEPTH) - count_q;
  assign full_o   = (free_cnt < (PTR_W+1)'(2));

  always_comb begin
    push_acc = push_valid_i && !full_o && !flush;
    push_n   = 2'd0;
    if (push_acc) begin
      push_n = push_single_i ? 2'd1 : 2'd2;
    end

    // Illegal encoding 3 behaves as a dual pop; then clip to what is present.
    pop_req = (pop_cnt_i == 2'd3) ? POP_TWO : pop_cnt_i;
    pop_n   = pop_req;
    if (count_q < (PTR_W+1)'(pop_req)) begin
      pop_n = count_q[1:0];
    end

    wr0_en   = push_acc;
    wr1_en   = push_acc && !push_single_i;
    wr0_data = '{pc: push_pc_i, inst: push_inst1_i};
    wr1_data = '{pc: next_pc(push_pc_i), inst: push_inst2_i};

    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; valids derived from count_q mask stale contents.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[tail_q]  <= wr0_data;
    if (wr1_en) mem_q[tail_p1] <= wr1_data;
  end

  assign inst1_o       = mem_q[head_q].inst;
  assign pc1_o         = mem_q[head_q].pc;
  assign inst2_o       = mem_q[head_p1].inst;
  assign pc2_o         = mem_q[head_p1].pc;
  assign inst1_valid_o = (count_q >= (PTR_W+1)'(1));
  assign inst2_valid_o = (count_q >= (PTR_W+1)'(2));
  assign count_o       = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid_i;
  logic        push_single_i;
  logic [31:0] push_pc_i;
  logic [31:0] push_inst1_i;
  logic [31:0] push_inst2_i;
  logic        full_o;
  logic [1:0]  pop_cnt_i;
  logic [31:0] inst1_o, pc1_o, inst2_o, pc2_o;
  logic        inst1_valid_o, inst2_valid_o;
  logic [4:0]  count_o;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {pc, inst} entries in program order, plus reference pointers.
  logic [63:0] exp_q[$];
  int          exp_head = 0;
  int          exp_tail = 0;

  inst_fetch_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .push_valid_i  (push_valid_i),
    .push_single_i (push_single_i),
    .push_pc_i     (push_pc_i),
    .push_inst1_i  (push_inst1_i),
    .push_inst2_i  (push_inst2_i),
    .full_o        (full_o),
    .pop_cnt_i     (pop_cnt_i),
    .inst1_o       (inst1_o),
    .pc1_o         (pc1_o),
    .inst1_valid_o (inst1_valid_o),
    .inst2_o       (inst2_o),
    .pc2_o         (pc2_o),
    .inst2_valid_o (inst2_valid_o),
    .count_o       (count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (dut.count_q > 5'd16) begin
        errors++;
        $display("FAIL invariant_count: count=%0d required <= 16", dut.count_q);
      end
      checks++;
      if (dut.tail_q !== 4'(dut.head_q + dut.count_q[3:0])) begin
        errors++;
        $display("FAIL invariant_tail: tail=%0d required %0d", dut.tail_q,
                 4'(dut.head_q + dut.count_q[3:0]));
      end
    end
  end

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic step(input logic pv, input logic sg, input logic [31:0] pc,
                      input logic [31:0] i1, input logic [31:0] i2,
                      input logic [1:0] pcnt, input logic fl);
    int sz;
    int pn;
    bit acc;
    push_valid_i  = pv;
    push_single_i = sg;
    push_pc_i     = pc;
    push_inst1_i  = i1;
    push_inst2_i  = i2;
    pop_cnt_i     = pcnt;
    flush         = fl;
    @(posedge clk);
    sz = exp_q.size();
    if (fl) begin
      exp_q.delete();
      exp_head = 0;
      exp_tail = 0;
    end else begin
      pn = (pcnt == 2'd3) ? 2 : int'(pcnt);
      if (pn > sz) pn = sz;
      acc = pv && ((16 - sz) >= 2);
      for (int k = 0; k < pn; k++) void'(exp_q.pop_front());
      exp_head = (exp_head + pn) % 16;
      if (acc) begin
        exp_q.push_back({pc, i1});
        exp_tail = (exp_tail + 1) % 16;
        if (!sg) begin
          exp_q.push_back({pc + 32'd4, i2});
          exp_tail = (exp_tail + 1) % 16;
        end
      end
    end
    #1;
    push_valid_i  = 1'b0;
    push_single_i = 1'b0;
    pop_cnt_i     = 2'd0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_head = 0;
    exp_tail = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, 0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 2'd0, 0);
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++;
    if (inst1_valid_o !== 1'b0) begin errors++; $display("FAIL reset_v1: got %b want 0", inst1_valid_o); end
    checks++;
    if (inst2_valid_o !== 1'b0) begin errors++; $display("FAIL reset_v2: got %b want 0", inst2_valid_o); end
    checks++;
    if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
  endtask

  task automatic test_dual_push_pop();
    step(1, 0, 32'hBFC0_0000, 32'h1111_1111, 32'h2222_2222, 2'd0, 0);
    checks++;
    if (pc1_o !== exp_q[0][63:32] || inst1_o !== exp_q[0][31:0]) begin
      errors++; $display("FAIL dual_head: got %h/%h want %h", pc1_o, inst1_o, exp_q[0]);
    end
    checks++;
    if (pc2_o !== exp_q[1][63:32] || inst2_o !== exp_q[1][31:0]) begin
      errors++; $display("FAIL dual_second: got %h/%h want %h", pc2_o, inst2_o, exp_q[1]);
    end
    checks++;
    if (pc2_o !== 32'hBFC0_0004) begin errors++; $display("FAIL dual_pc2: got %h want bfc00004", pc2_o); end
    checks++;
    if (inst1_valid_o !== 1'b1 || inst2_valid_o !== 1'b1 || count_o !== 5'(exp_q.size())) begin
      errors++; $display("FAIL dual_valid: got v1=%b v2=%b cnt=%0d want 1 1 %0d",
                         inst1_valid_o, inst2_valid_o, count_o, exp_q.size());
    end
    step(0, 0, 0, 0, 0, 2'd2, 0);
    checks++;
    if (count_o !== 5'(exp_q.size())) begin errors++; $display("FAIL dual_pop_count: got %0d want %0d", count_o, exp_q.size()); end
  endtask

  task automatic test_single_overpop();
    step(1, 1, 32'h8000_0010, 32'hCAFE_0001, 32'hDEAD_DEAD, 2'd0, 0);
    checks++;
    if (count_o !== 5'd1 || inst1_valid_o !== 1'b1 || inst2_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_state: got cnt=%0d v1=%b v2=%b want 1 1 0", count_o, inst1_valid_o, inst2_valid_o);
    end
    checks++;
    if (pc1_o !== exp_q[0][63:32] || inst1_o !== exp_q[0][31:0]) begin
      errors++; $display("FAIL single_head: got %h/%h want %h", pc1_o, inst1_o, exp_q[0]);
    end
    step(0, 0, 0, 0, 0, 2'd3, 0);
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL overpop_count: got %0d want 0", count_o); end
    checks++;
    if (dut.head_q !== 4'(exp_head)) begin errors++; $display("FAIL overpop_head: got %0d want %0d", dut.head_q, exp_head); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 32'h0000_1000 + 32'(8 * k), 32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k), 2'd0, 0);
      checks++;
      if (count_o !== 5'(exp_q.size()) || full_o !== (exp_q.size() >= 15)) begin
        errors++; $display("FAIL fill_%0d: got cnt=%0d full=%b want %0d %b", k, count_o, full_o,
                           exp_q.size(), exp_q.size() >= 15);
      end
    end
    step(1, 0, 32'h0000_2000, 32'hEEEE_EEEE, 32'hFFFF_FFFF, 2'd0, 0);
    checks++;
    if (count_o !== 5'd16 || full_o !== 1'b1) begin
      errors++; $display("FAIL drop_state: got cnt=%0d full=%b want 16 1", count_o, full_o);
    end
    checks++;
    if (pc1_o !== exp_q[0][63:32] || inst1_o !== exp_q[0][31:0]) begin
      errors++; $display("FAIL drop_head: got %h/%h want %h", pc1_o, inst1_o, exp_q[0]);
    end
    step(1, 0, 32'h0000_3000, 32'h1234_0000, 32'h1234_0001, 2'd2, 0);
    checks++;
    if (count_o !== 5'd14 || full_o !== 1'b0) begin
      errors++; $display("FAIL pop_while_full: got cnt=%0d full=%b want 14 0", count_o, full_o);
    end
    // Drain, comparing every delivered pair against the scoreboard front.
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (inst1_o !== exp_q[0][31:0] || pc1_o !== exp_q[0][63:32] ||
          inst2_o !== exp_q[1][31:0] || pc2_o !== exp_q[1][63:32]) begin
        errors++; $display("FAIL drain_%0d: got %h/%h %h/%h want %h %h", k, pc1_o, inst1_o,
                           pc2_o, inst2_o, exp_q[0], exp_q[1]);
      end
      step(0, 0, 0, 0, 0, 2'd2, 0);
    end
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      step(1, 1, 32'h0000_4000 + 32'(4 * k), 32'h5000_0000 + 32'(k), 32'h0, 2'd0, 0);
      checks++;
      if (inst1_o !== exp_q[0][31:0] || count_o !== 5'd1) begin
        errors++; $display("FAIL wrap_single_%0d: got %h cnt=%0d want %h 1", k, inst1_o, count_o, exp_q[0][31:0]);
      end
      step(0, 0, 0, 0, 0, 2'd1, 0);
    end
    checks++;
    if (dut.head_q !== 4'(exp_head) || exp_head != 15) begin
      errors++; $display("FAIL wrap_head: got %0d want 15", dut.head_q);
    end
    step(1, 0, 32'h0000_5000, 32'hAAAA_0000, 32'hBBBB_0000, 2'd0, 0);
    checks++;
    if (inst1_o !== 32'hAAAA_0000 || inst1_o !== exp_q[0][31:0]) begin
      errors++; $display("FAIL wrap_inst1: got %h want aaaa0000", inst1_o);
    end
    checks++;
    if (inst2_o !== 32'hBBBB_0000 || pc2_o !== exp_q[1][63:32]) begin
      errors++; $display("FAIL wrap_inst2: got %h/%h want bbbb0000/%h", inst2_o, pc2_o, exp_q[1][63:32]);
    end
    step(0, 0, 0, 0, 0, 2'd2, 0);
    checks++;
    if (count_o !== 5'd0 || dut.head_q !== 4'(exp_head)) begin
      errors++; $display("FAIL wrap_drain: got cnt=%0d head=%0d want 0 %0d", count_o, dut.head_q, exp_head);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 32'h0000_6000 + 32'(8 * k), 32'h6000_0000 + 32'(k), 32'h6100_0000 + 32'(k), 2'd0, 0);
    end
    checks++;
    if (count_o !== 5'd6) begin errors++; $display("FAIL flush_pre: got %0d want 6", count_o); end
    step(1, 0, 32'h0000_7000, 32'h7777_7777, 32'h7878_7878, 2'd1, 1);
    checks++;
    if (count_o !== 5'd0 || inst1_valid_o !== 1'b0 || inst2_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_state: got cnt=%0d v1=%b v2=%b want 0 0 0", count_o, inst1_valid_o, inst2_valid_o);
    end
    checks++;
    if (dut.head_q !== 4'd0 || dut.tail_q !== 4'd0) begin
      errors++; $display("FAIL flush_ptrs: got head=%0d tail=%0d want 0 0", dut.head_q, dut.tail_q);
    end
    step(1, 1, 32'h0000_8000, 32'h8888_0001, 32'h0, 2'd0, 0);
    checks++;
    if (count_o !== 5'd1 || pc1_o !== exp_q[0][63:32] || inst1_o !== exp_q[0][31:0]) begin
      errors++; $display("FAIL post_flush_push: got cnt=%0d %h/%h want 1 %h", count_o, pc1_o, inst1_o, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_push();
    push_valid_i  = 1'b1;
    push_single_i = 1'b0;
    push_pc_i     = 32'h0000_9000;
    push_inst1_i  = 32'h9999_0001;
    push_inst2_i  = 32'h9999_0002;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (count_o !== 5'd0 || inst1_valid_o !== 1'b0 || inst2_valid_o !== 1'b0 || full_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got cnt=%0d v1=%b v2=%b full=%b want 0 0 0 0",
                         count_o, inst1_valid_o, inst2_valid_o, full_o);
    end
    push_valid_i = 1'b0;
    exp_q.delete();
    exp_head = 0;
    exp_tail = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 2'd0, 0);
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL after_reset: got %0d want 0", count_o); end
  endtask

  initial begin
    rst           = 1'b0;
    flush         = 1'b0;
    push_valid_i  = 1'b0;
    push_single_i = 1'b0;
    push_pc_i     = '0;
    push_inst1_i  = '0;
    push_inst2_i  = '0;
    pop_cnt_i     = 2'd0;
    test_reset();
    test_dual_push_pop();
    test_single_overpop();
    test_fill();
    test_wrap();
    test_flush();
    test_reset_mid_push();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-entry-per-cycle instruction queue placed between the ICache fetch outputs (inst1/inst2, valid, single_shot) and the dual-issue decode stage.
- Decouples ICache miss stalls from decode.
- Accepts 1 or 2 instructions per cycle and delivers up to 2 per cycle in program order with their PCs.
- Flushed on branch mispredict or exception redirect.

Parameters:
- DEPTH, 16, number of {pc, inst} entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear; takes priority over push and pop.
- push_valid_i  in  1  ICache inst_valid for this cycle.
- push_single_i  in  1  only inst1 is valid (ICache single_shot).
- push_pc_i  in  32  PC of inst1; inst2 PC is push_pc_i+4.
- push_inst1_i  in  32  first instruction.
- push_inst2_i  in  32  second instruction.
- full_o  in→out  1  output; free entries < 2; fetch must hold.
- pop_cnt_i  in  2  entries decode consumes this cycle: 0, 1 or 2; 3 is illegal and treated as 2.
- inst1_o  out  32  head entry instruction.
- pc1_o  out  32  head entry PC.
- inst1_valid_o  out  1  count ≥ 1.
- inst2_o  out  32  head+1 entry instruction.
- pc2_o  out  32  head+1 entry PC.
- inst2_valid_o  out  1  count ≥ 2.
- count_o  out  PTR_W+1  current occupancy.

Behaviour:
- Storage: circular array of DEPTH entries, each {pc[31:0], inst[31:0]}. Registers: head, tail (PTR_W bits, wrap mod DEPTH), count (PTR_W+1 bits).
- Reset (rst=0, asynchronous): head=0, tail=0, count=0. Consequently inst1_valid_o=0, inst2_valid_o=0, full_o=0, count_o=0. inst/pc outputs read array contents; they are don't-care while the matching valid is 0. The array itself is not reset.
- Read side is combinational from registers: entry[head] → inst1_o/pc1_o; entry[head+1 mod DEPTH] → inst2_o/pc2_o.
- full_o = (DEPTH - count) < 2, registered-derived combinational. There is no partial-accept mode: a push is either fully accepted or fully dropped.
- Push accepted iff push_valid_i && !full_o && !flush.
  - Writes 1 entry if push_single_i, else 2.
  - entry[tail] = {push_pc_i, push_inst1_i}.
  - For a two-entry push, entry[tail+1] = {push_pc_i+4, push_inst2_i}.
  - tail advances by the accepted amount mod DEPTH.
  - A push while full_o=1 is dropped silently; fetch is required to hold and retry.
- Pop: effective pop = min(pop_cnt_i clipped to 2, count), computed on the pre-update count. head advances by the effective pop mod DEPTH. Popping an empty queue is a no-op.
- Simultaneous push and pop in one cycle: count_next = count + push_n - pop_n. A pop frees space only for the next cycle, because full_o is computed from the current count.
- Flush: on the next edge head=0, tail=0, count=0. Push and pop in the same cycle are ignored. Outputs show empty from the following cycle.
- Latency: a pushed instruction appears on inst1_o/inst2_o one cycle after acceptance (write edge → visible next cycle). There is no bypass.
- Wrap-around: a two-entry push at tail=DEPTH-1 writes entries DEPTH-1 and 0. A read of head=DEPTH-1 shows inst2 from entry 0.
- Invariant: count ≤ DEPTH at all times. The bench asserts this, and asserts tail == (head + count) mod DEPTH.

Decomposition:
- Shared package/defines file holds: entry width constant (64), `InstBus` and `InstAddrBus` reuse, and the pop-count encoding constants POP_NONE=0, POP_ONE=1, POP_TWO=2.
- No sub-module is needed. The storage array is inferred distributed RAM with two read ports and two write ports, inside the module.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, no traffic → count_o=0, inst1_valid_o=0, inst2_valid_o=0, full_o=0.
- Dual push then dual pop: push pc=0xBFC00000, inst1=0x11111111, inst2=0x22222222.
  - Next cycle: pc1_o=0xBFC00000, pc2_o=0xBFC00004, both valid, count_o=2.
  - pop_cnt_i=2 → count_o=0.
- Single-shot push plus over-pop: push_single_i=1, pc=0x80000010 → count_o=1, only inst1_valid_o=1. Then pop_cnt_i=2 → count_o=0 and head advances by exactly 1.
- Fill to full: 8 dual pushes with no pops → count_o=16, full_o=1 once count reaches 15.
  - A 9th push is dropped: count stays 16 and contents are unchanged.
  - A simultaneous pop of 2 with push gives count 14 next cycle, with full_o=0 from the cycle after.
- Wrap-around: drive head and tail to 15 via 15 single push/pop pairs. Dual push 0xAAAA0000/0xBBBB0000 → inst1_o=0xAAAA0000 from entry 15, inst2_o=0xBBBB0000 from entry 0.
- Flush priority: count=6, then flush=1 together with push_valid_i=1 and pop_cnt_i=1 → next cycle count_o=0, both valids 0, and the pushed data is not visible. Also assert rst=0 mid-push → outputs clear immediately, without waiting for a clock edge.
